// File: rtl/memstage_pkg.sv
// memstage_pkg: shared definitions for the MIPS memory stage.
// Contents: default data/address width, default destination-register index
// width, and the memory-port FSM state type.
package memstage_pkg;

    localparam int MS_XLEN = 32;
    localparam int MS_RD_W = 5;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } msState_t;

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: request/acknowledge data-memory port.
// Signals:
//   dmem_req   - request valid (stage -> memory)
//   dmem_we    - 1 = write, 0 = read (stage -> memory)
//   dmem_addr  - byte address (stage -> memory)
//   dmem_wdata - store data (stage -> memory)
//   dmem_ack   - request completed this cycle (memory -> stage)
//   dmem_rdata - read data, valid with dmem_ack on a read (memory -> stage)
// Modports: master = memory stage, slave = data memory.
interface memory_stage_if
    import memstage_pkg::*;
#(
    parameter int XLEN = MS_XLEN
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_stage_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
// Ports:
//   clk, rst                       - clock, async active-high reset (clears all)
//   bubble                         - clear control fields, hold data fields
//   regwriteIn/isloadIn/rdIn       - control fields from the M stage
//   pcplus4In/aluresultIn/readdataIn - data fields from the M stage
//   *Out                           - registered W-stage values
//   misalignIn/misalignOut         - only with MEMSTAGE_ALIGN_CHECK_EN
module mem_wb_reg
    import memstage_pkg::*;
#(
    parameter int XLEN = MS_XLEN,
    parameter int RD_W = MS_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bubble,
    input  logic            regwriteIn,
    input  logic            isloadIn,
    input  logic [RD_W-1:0] rdIn,
    input  logic [XLEN-1:0] pcplus4In,
    input  logic [XLEN-1:0] aluresultIn,
    input  logic [XLEN-1:0] readdataIn,
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    input  logic            misalignIn,
    output logic            misalignOut,
`endif
    output logic            regwriteOut,
    output logic            isloadOut,
    output logic [RD_W-1:0] rdOut,
    output logic [XLEN-1:0] pcplus4Out,
    output logic [XLEN-1:0] aluresultOut,
    output logic [XLEN-1:0] readdataOut
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwriteOut  <= 1'b0;
            isloadOut    <= 1'b0;
            rdOut        <= '0;
            pcplus4Out   <= '0;
            aluresultOut <= '0;
            readdataOut  <= '0;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
            misalignOut  <= 1'b0;
`endif
        end else if (bubble) begin
            // Bubble: kill the write-back, keep data so forwarding stays stable.
            regwriteOut  <= 1'b0;
            isloadOut    <= 1'b0;
            rdOut        <= '0;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
            misalignOut  <= 1'b0;
`endif
        end else begin
            regwriteOut  <= regwriteIn;
            isloadOut    <= isloadIn;
            rdOut        <= rdIn;
            pcplus4Out   <= pcplus4In;
            aluresultOut <= aluresultIn;
            readdataOut  <= readdataIn;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
            misalignOut  <= misalignIn;
`endif
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage MIPS pipeline.
// Issues loads/stores on a req/ack data-memory port, stalls upstream while the
// memory is busy, and drives the MEM/WB register.
// Ports:
//   clk, rst        - clock, async active-high reset
//   *M inputs       - EX/MEM register outputs
//   dmem            - data-memory port (memory_stage_if.master)
//   stallM          - freeze PC, IF/ID, ID/EX, EX/MEM
//   *W outputs      - MEM/WB register (aluresultW/readdataW feed forwarding)
//   misalignW       - misaligned access flag, only with MEMSTAGE_ALIGN_CHECK_EN
// Optional feature macro: MEMSTAGE_ALIGN_CHECK_EN (alignment check).
module memory_stage
    import memstage_pkg::*;
#(
    parameter int XLEN = MS_XLEN,
    parameter int RD_W = MS_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwriteM,
    input  logic            memwriteM,
    input  logic            isloadM,
    input  logic            memreadM,
    input  logic [RD_W-1:0] rdM,
    input  logic [XLEN-1:0] pcplus4M,
    input  logic [XLEN-1:0] aluresultM,
    input  logic [XLEN-1:0] writedataM,
    memory_stage_if.master  dmem,
    output logic            stallM,
    output logic            regwriteW,
    output logic            isloadW,
    output logic [RD_W-1:0] rdW,
    output logic [XLEN-1:0] pcplus4W,
    output logic [XLEN-1:0] aluresultW,
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    output logic            misalignW,
`endif
    output logic [XLEN-1:0] readdataW
);

    msState_t        state, nextState;
    logic [XLEN-1:0] capAddr, capWdata;
    logic            capWe;
    logic            access, misalign, issue;
    logic [XLEN-1:0] readdataNext;

    assign access = memreadM | memwriteM;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    assign misalign = access & (aluresultM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign issue = access & ~misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MS_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Request fields are latched on entry to WAIT so they stay stable for
    // the whole transaction regardless of what the M inputs do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capAddr  <= '0;
            capWdata <= '0;
            capWe    <= 1'b0;
        end else if (state == MS_IDLE && nextState == MS_WAIT) begin
            capAddr  <= aluresultM;
            capWdata <= writedataM;
            capWe    <= memwriteM;
        end
    end

    always_comb begin
        nextState       = state;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = memwriteM;
        dmem.dmem_addr  = aluresultM;
        dmem.dmem_wdata = writedataM;
        unique case (state)
            MS_IDLE: begin
                dmem.dmem_req = issue;
                if (issue && !dmem.dmem_ack) begin
                    nextState = MS_WAIT;
                end
            end
            MS_WAIT: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = capWe;
                dmem.dmem_addr  = capAddr;
                dmem.dmem_wdata = capWdata;
                if (dmem.dmem_ack) begin
                    nextState = MS_IDLE;
                end
            end
            default: nextState = MS_IDLE;
        endcase
    end

    assign stallM = dmem.dmem_req & ~dmem.dmem_ack;

    // Read data only for an issued read; read+write counts as a write.
    assign readdataNext = (dmem.dmem_req && !dmem.dmem_we) ? dmem.dmem_rdata : '0;

    mem_wb_reg #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) uMemWb (
        .clk          (clk),
        .rst          (rst),
        .bubble       (stallM),
        .regwriteIn   (regwriteM & ~misalign),
        .isloadIn     (isloadM),
        .rdIn         (rdM),
        .pcplus4In    (pcplus4M),
        .aluresultIn  (aluresultM),
        .readdataIn   (readdataNext),
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        .misalignIn   (misalign),
        .misalignOut  (misalignW),
`endif
        .regwriteOut  (regwriteW),
        .isloadOut    (isloadW),
        .rdOut        (rdW),
        .pcplus4Out   (pcplus4W),
        .aluresultOut (aluresultW),
        .readdataOut  (readdataW)
    );

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// Each instruction is described by its kind, operands and memory latency; the
// expected port behaviour and W values come from a transaction-level model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteM, memwriteM, isloadM, memreadM;
    logic [4:0]  rdM;
    logic [31:0] pcplus4M, aluresultM, writedataM;
    logic        stallM, regwriteW, isloadW;
    logic [4:0]  rdW;
    logic [31:0] pcplus4W, aluresultW, readdataW;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    logic        misalignW;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: last completed W values
    logic        expRw, expIsload, expMis;
    logic [4:0]  expRd;
    logic [31:0] expPc, expAlu, expRdata;

    memory_stage_if #(.XLEN(32)) dmem ();

    memory_stage #(
        .XLEN (32),
        .RD_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .regwriteM  (regwriteM),
        .memwriteM  (memwriteM),
        .isloadM    (isloadM),
        .memreadM   (memreadM),
        .rdM        (rdM),
        .pcplus4M   (pcplus4M),
        .aluresultM (aluresultM),
        .writedataM (writedataM),
        .dmem       (dmem),
        .stallM     (stallM),
        .regwriteW  (regwriteW),
        .isloadW    (isloadW),
        .rdW        (rdW),
        .pcplus4W   (pcplus4W),
        .aluresultW (aluresultW),
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        .misalignW  (misalignW),
`endif
        .readdataW  (readdataW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkW(input string pfx);
        check({pfx, ".regwriteW"}, regwriteW, expRw);
        check({pfx, ".isloadW"},   isloadW,   expIsload);
        check({pfx, ".rdW"},       rdW,       expRd);
        check({pfx, ".pcplus4W"},  pcplus4W,  expPc);
        check({pfx, ".aluresultW"}, aluresultW, expAlu);
        check({pfx, ".readdataW"}, readdataW, expRdata);
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        check({pfx, ".misalignW"}, misalignW, expMis);
`endif
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = read+write. lat = cycles before ack.
    // Called just after a rising edge; returns just after the completing edge.
    task automatic runInstr(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                            input int lat);
        logic acc, mis, issue;
        int   n;
        regwriteM  = rw;
        memreadM   = (kind == 1 || kind == 3);
        memwriteM  = (kind >= 2);
        isloadM    = (kind == 1);
        rdM        = rd;
        pcplus4M   = $urandom;
        aluresultM = addr;
        writedataM = wdata;
        acc = memreadM | memwriteM;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        mis = acc && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        issue = acc && !mis;
        n = issue ? lat : 0;
        for (int c = 0; c <= n; c++) begin
            // With no request outstanding, ack is noise that must be ignored.
            dmem.dmem_ack   = issue ? (c == n) : 1'($urandom_range(0, 1));
            dmem.dmem_rdata = (c == n) ? rdata : $urandom;
            @(negedge clk);
            check("dmem_req", dmem.dmem_req, issue);
            check("stallM", stallM, issue && (c < n));
            if (issue) begin
                check("dmem_addr", dmem.dmem_addr, addr);
                check("dmem_we", dmem.dmem_we, memwriteM);
                check("dmem_wdata", dmem.dmem_wdata, wdata);
            end
            @(posedge clk);
            #1;
            if (c < n) begin
                check("bubble.regwriteW", regwriteW, 1'b0);
                check("bubble.isloadW", isloadW, 1'b0);
                check("bubble.rdW", rdW, 5'd0);
                check("bubble.aluresultW", aluresultW, expAlu);
                check("bubble.readdataW", readdataW, expRdata);
            end
        end
        expRw     = rw && !mis;
        expIsload = isloadM;
        expRd     = rd;
        expPc     = pcplus4M;
        expAlu    = addr;
        expRdata  = (issue && memreadM && !memwriteM) ? rdata : 32'd0;
        expMis    = mis;
        checkW("wb");
        dmem.dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {regwriteM, memwriteM, isloadM, memreadM} = '0;
        rdM = '0; pcplus4M = '0; aluresultM = '0; writedataM = '0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
        {expRw, expIsload, expMis} = '0;
        expRd = '0; expPc = '0; expAlu = '0; expRdata = '0;

        // Reset state; the IDLE request term still follows the M inputs.
        @(negedge clk);
        checkW("reset");
        check("reset.req_idle", dmem.dmem_req, 1'b0);
        memreadM = 1'b1;
        aluresultM = 32'h40;
        #1;
        check("reset.req_follows", dmem.dmem_req, 1'b1);
        check("reset.stall_follows", stallM, 1'b1);
        memreadM = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        runInstr(1, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 1'b1, 0);   // zero-wait load
        runInstr(2, 32'h200, 32'h12345678, 32'hCAFEF00D, 5'd3, 1'b0, 3); // 3-cycle store
        runInstr(0, 32'h55, 32'h0, 32'hFFFFFFFF, 5'd9, 1'b1, 0);     // ALU pass-through
        runInstr(3, 32'h300, 32'hA5A5A5A5, 32'h11111111, 5'd4, 1'b1, 2); // read+write
        runInstr(1, 32'h104, 32'h0, 32'h0BADF00D, 5'd5, 1'b1, 1);    // back-to-back after WAIT
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        runInstr(1, 32'h103, 32'h0, 32'h22222222, 5'd6, 1'b1, 2);    // misaligned load
        runInstr(0, 32'h77, 32'h0, 32'h0, 5'd8, 1'b1, 0);            // misalignW drops
`endif

        // Reset mid-WAIT
        regwriteM = 1'b1; memreadM = 1'b1; memwriteM = 1'b0; isloadM = 1'b1;
        rdM = 5'd12; aluresultM = 32'h400; dmem.dmem_ack = 1'b0;
        @(negedge clk);
        check("rstwait.stall1", stallM, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstwait.stall2", stallM, 1'b1);
        {regwriteM, memwriteM, isloadM, memreadM} = '0;
        rdM = '0; pcplus4M = '0; aluresultM = '0; writedataM = '0;
        #1;
        check("rstwait.req_wait", dmem.dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rstwait.req_drop", dmem.dmem_req, 1'b0);
        check("rstwait.stall_drop", stallM, 1'b0);
        {expRw, expIsload, expMis} = '0;
        expRd = '0; expPc = '0; expAlu = '0; expRdata = '0;
        checkW("rstwait");
        #1;
        rst = 1'b0;
        dmem.dmem_ack = 1'b1;
        dmem.dmem_rdata = 32'h99999999;
        @(posedge clk);
        #1;
        check("lateack.req", dmem.dmem_req, 1'b0);
        checkW("lateack");
        dmem.dmem_ack = 1'b0;

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            runInstr(int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                     5'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs produced by the execute stage and performs the load/store through a request/acknowledge data-memory port. Stalls the upstream pipeline while the memory is busy, then drives the MEM/WB register. Its `aluresultW` and `readdataW` outputs are the W-stage values used by the execute-stage forwarding muxes.

## Interface
Parameters:
- `XLEN`, 32: data/address width.
- `RD_W`, 5: destination register index width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `regwriteM` in 1: instruction writes the register file.
- `memwriteM` in 1: store.
- `isloadM` in 1: writeback selects load data.
- `memreadM` in 1: load.
- `rdM` in RD_W: destination register.
- `pcplus4M` in XLEN: PC+4 of the instruction.
- `aluresultM` in XLEN: effective address, or ALU result.
- `writedataM` in XLEN: store data.
- `dmem_req` out 1: memory request valid.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out XLEN: byte address.
- `dmem_wdata` out XLEN: store data.
- `dmem_ack` in 1: request completed this cycle.
- `dmem_rdata` in XLEN: read data, valid when `dmem_ack` is 1 for a read.
- `stallM` out 1: freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- `regwriteW` out 1: MEM/WB register-write control.
- `isloadW` out 1: MEM/WB load select.
- `rdW` out RD_W: MEM/WB destination register.
- `pcplus4W` out XLEN: MEM/WB PC+4.
- `aluresultW` out XLEN: MEM/WB ALU result.
- `readdataW` out XLEN: MEM/WB load data.
- `misalignW` out 1: misaligned access flag. Present only with `MEMSTAGE_ALIGN_CHECK_EN`.

## Operation
- Access is defined as `memreadM | memwriteM`. If both are set, the access is a write and `readdataW` is 0.
- FSM states:
  - IDLE:
    - Access with `dmem_ack`=1 the same cycle: complete in zero wait states, stay in IDLE.
    - Access with `dmem_ack`=0: go to WAIT and capture the address, write data and write enable.
  - WAIT:
    - Drive the captured values.
    - On `dmem_ack`=1: go to IDLE.
- `dmem_req` = (IDLE & access) | WAIT.
- `dmem_addr` = `aluresultM` in IDLE, captured value in WAIT. The same rule applies to `dmem_we` and `dmem_wdata`.
- While `dmem_req`=1, `dmem_addr`, `dmem_we` and `dmem_wdata` are stable.
- `dmem_ack` is ignored when `dmem_req`=0.
- `stallM` = `dmem_req` & ~`dmem_ack` (combinational).
- MEM/WB update on each rising edge:
  - `stallM`=0: all W outputs load their M inputs. `readdataW` loads `dmem_rdata` for a read, 0 otherwise.
  - `stallM`=1: insert a bubble. `regwriteW`, `isloadW` and `rdW` are set to 0; the data fields hold their values.
- Non-memory instructions pass through with no request and no stall.

## Timing
- Reset (async):
  - State = IDLE.
  - `dmem_req` and `stallM` follow the combinational rule above. Only the WAIT term is cleared by reset; the IDLE-access term still follows the M inputs.
  - All W outputs = 0, including `misalignW`.
  - Reset during WAIT abandons the transaction. The WAIT term of `dmem_req` drops asynchronously, and any later `dmem_ack` for it is ignored.
- Latency:
  - Zero-wait memory: M to W in 1 cycle, `stallM` never asserted.
  - Ack after N cycles: `stallM` is high for N cycles, and the W update happens on the edge where `dmem_ack`=1.
- Back-to-back accesses: with zero-wait memory, one access per cycle. After a WAIT completes, the next access can issue in the IDLE cycle that follows.

## Configuration
- `MEMSTAGE_ALIGN_CHECK_EN` defined:
  - An access with `aluresultM[1:0]`≠0 issues no request and does not stall.
  - On the next edge: `misalignW`=1 and `regwriteW`=0. The other W fields load normally, with `readdataW`=0.
  - `misalignW` is high for exactly one cycle per misaligned instruction.
- `MEMSTAGE_ALIGN_CHECK_EN` undefined:
  - The `misalignW` port is absent.
  - The address is passed through unmodified.

## Structure
- `memstage_pkg`:
  - FSM state enum (`MS_IDLE`, `MS_WAIT`).
  - Default `XLEN` and `RD_W` constants.
- Sub-module `mem_wb_reg`: the MEM/WB pipeline register with async reset and a bubble input. The FSM and memory-port logic stay in `memory_stage`.

## Test plan
- Zero-wait load: `memreadM`=1, `aluresultM`=0x100, `dmem_ack`=1 same cycle, `dmem_rdata`=0xDEADBEEF → `stallM` never 1; next edge `readdataW`=0xDEADBEEF, `isloadW`=1, `rdW`=`rdM`.
- 3-cycle store: `memwriteM`=1, address 0x200, data 0x12345678, ack on cycle 3 → `stallM` high for 3 cycles; `dmem_addr`, `dmem_wdata` and `dmem_we`=1 stable throughout; `regwriteW`=0 during the stall; `dmem_req` low after the ack.
- ALU pass-through: `regwriteM`=1, `aluresultM`=0x55, no access → `dmem_req`=0; next edge `aluresultW`=0x55, `readdataW`=0.
- Reset mid-WAIT: load pending for 2 cycles, then pulse `rst` → `dmem_req` drops immediately; W outputs = 0; a late `dmem_ack` while `dmem_req`=0 leaves the W outputs unchanged.
- Misaligned load with the macro: `aluresultM`=0x103 → `dmem_req`=0; next edge `misalignW`=1, `regwriteW`=0; following cycle `misalignW`=0.
- Read and write both set: `memreadM`=`memwriteM`=1 → `dmem_we`=1; `readdataW`=0 after the ack.
